sd_init_ctrl: RTL and testbench

SPI-mode SD card command sequencer that drives the existing 48-bit command serializer (send/command/argument/done interface) and receives R1 responses on the card's data-out line. After `start` it runs power-up clocks, then CMD0 → (CMD55, ACMD41)* → CMD16(512) and reaches READY. In READY it issues single-block read commands (CMD17) on request and reports each R1. Data-token and data-block reception belong to a separate block.

---
 rtl/sd_pkg.sv | 71 +++++++
 rtl/sd_r1_rx.sv | 88 ++++++++
 rtl/sd_init_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_sd_init_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants and types for the SPI-mode SD init / read-command sequencer.
package sd_pkg;

  // Command indices as sent to the 48-bit serializer.
  localparam logic [5:0] CMD0_IDX   = 6'd0;
  localparam logic [5:0] CMD16_IDX  = 6'd16;
  localparam logic [5:0] CMD17_IDX  = 6'd17;
  localparam logic [5:0] CMD55_IDX  = 6'd55;
  localparam logic [5:0] ACMD41_IDX = 6'd41;

  // CMD16 argument: 512-byte block length.
  localparam logic [31:0] BLOCK_LEN = 32'd512;

  // R1 bit masks.
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;

  // err_code values.
  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_NO_RESP    = 3'd1;
  localparam logic [2:0] ERR_CMD0       = 3'd2;
  localparam logic [2:0] ERR_CMD55      = 3'd3;
  localparam logic [2:0] ERR_ACMD41_REJ = 3'd4;
  localparam logic [2:0] ERR_ACMD41_TMO = 3'd5;
  localparam logic [2:0] ERR_CMD16      = 3'd6;

  // Main sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_POWERUP    = 4'd1,
    ST_ISSUE      = 4'd2,
    ST_TX_WAIT    = 4'd3,
    ST_RESP_WAIT  = 4'd4,
    ST_RESP_SHIFT = 4'd5,
    ST_GAP        = 4'd6,
    ST_DECIDE     = 4'd7,
    ST_READY      = 4'd8,
    ST_ERROR      = 4'd9
  } sd_state_e;

  // Which command the sequencer is currently working on.
  typedef enum logic [2:0] {
    STEP_CMD0   = 3'd0,
    STEP_CMD55  = 3'd1,
    STEP_ACMD41 = 3'd2,
    STEP_CMD16  = 3'd3,
    STEP_CMD17  = 3'd4
  } sd_step_e;

  // R1 receiver states.
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SEARCH = 2'd1,
    RX_SHIFT  = 2'd2
  } rx_state_e;

  // Map a step to the command index presented to the serializer.
  function automatic logic [5:0] step_index(input sd_step_e step);
    logic [5:0] idx;
    case (step)
      STEP_CMD0:   idx = CMD0_IDX;
      STEP_CMD55:  idx = CMD55_IDX;
      STEP_ACMD41: idx = ACMD41_IDX;
      STEP_CMD16:  idx = CMD16_IDX;
      STEP_CMD17:  idx = CMD17_IDX;
      default:     idx = CMD0_IDX;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sd_r1_rx.sv
// R1 receiver: after arm, hunts for the response start bit (a 0 on MISO) for
// up to NCR_MAX clocks, then shifts the remaining 7 bits MSB-first.
// found/valid/timeout are single-cycle strobes derived from the bit being
// sampled this clock, so the parent can act on the same edge.
module sd_r1_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm,
  input  logic       sdin,
  output logic       found,
  output logic       valid,
  output logic       timeout,
  output logic [7:0] r1,
  output rx_state_e  rx_state
);

  localparam int CNT_W = $clog2(NCR_MAX + 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] ncr_cnt_q, ncr_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;

  // Next-state logic for the start-bit search and the 7-bit shift.
  always_comb begin
    state_d   = state_q;
    ncr_cnt_d = ncr_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    found     = 1'b0;
    valid     = 1'b0;
    timeout   = 1'b0;
    r1        = {shift_q, sdin};
    case (state_q)
      RX_IDLE: begin
        if (arm) begin
          state_d   = RX_SEARCH;
          ncr_cnt_d = '0;
        end
      end
      RX_SEARCH: begin
        if (!sdin) begin
          // The start bit is R1 bit7 (always 0).
          found     = 1'b1;
          state_d   = RX_SHIFT;
          shift_d   = 7'd0;
          bit_cnt_d = '0;
        end else if (ncr_cnt_q == CNT_W'(NCR_MAX - 1)) begin
          timeout = 1'b1;
          state_d = RX_IDLE;
        end else begin
          ncr_cnt_d = ncr_cnt_q + CNT_W'(1);
        end
      end
      RX_SHIFT: begin
        shift_d   = {shift_q[5:0], sdin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd6) begin
          valid   = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      ncr_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      ncr_cnt_q <= ncr_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign rx_state = state_q;

endmodule

// File: rtl/sd_init_ctrl.sv
// SPI-mode SD command sequencer: power-up clocks, CMD0, (CMD55, ACMD41)*,
// CMD16(512), then READY where CMD17 single-block read commands are issued
// on request. Only R1 responses are handled here.
//
// Serializer handshake: cmd_send is a 1-cycle load strobe with cmd_index and
// cmd_arg valid on that cycle (and held until the next load). The serializer
// keeps cmd_done high from the end of a frame until the edge after the next
// load, so cmd_done is ignored while cmd_send is high; the first cmd_done=1
// seen after that marks the end of the transmitted frame.
module sd_init_ctrl
  import sd_pkg::*;
#(
  parameter int INIT_CLKS    = 80,
  parameter int NCR_MAX      = 128,
  parameter int GAP_CLKS     = 8,
  parameter int CMD0_TRIES   = 8,
  parameter int ACMD41_TRIES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        SDin,
  input  logic        cmd_done,
  output logic        cmd_send,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cs_n,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_done,
  output logic        busy,
  output logic        ready,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [7:0]  last_r1,
  output sd_state_e   dbg_state,
  output rx_state_e   dbg_rx_state
);

  sd_state_e   state_q, state_d;
  sd_step_e    step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cmd0_tries_q, cmd0_tries_d;
  logic [15:0] acmd41_tries_q, acmd41_tries_d;
  logic        cmd_send_q, cmd_send_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_done_q, rd_done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [7:0]  last_r1_q, last_r1_d;
  logic [31:0] rd_addr_q, rd_addr_d;

  logic       rx_arm;
  logic       rx_found;
  logic       rx_valid;
  logic       rx_timeout;
  logic [7:0] rx_r1;

  sd_r1_rx #(
    .NCR_MAX (NCR_MAX)
  ) u_r1_rx (
    .clock    (clock),
    .reset    (reset),
    .arm      (rx_arm),
    .sdin     (SDin),
    .found    (rx_found),
    .valid    (rx_valid),
    .timeout  (rx_timeout),
    .r1       (rx_r1),
    .rx_state (dbg_rx_state)
  );

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    cnt_d          = cnt_q;
    cmd0_tries_d   = cmd0_tries_q;
    acmd41_tries_d = acmd41_tries_q;
    cmd_send_d     = 1'b0;
    cmd_index_d    = cmd_index_q;
    cmd_arg_d      = cmd_arg_q;
    cs_n_d         = cs_n_q;
    rd_done_d      = 1'b0;
    err_code_d     = err_code_q;
    last_r1_d      = last_r1_q;
    rd_addr_d      = rd_addr_q;
    rx_arm         = 1'b0;

    case (state_q)
      ST_IDLE, ST_READY, ST_ERROR: begin
        if (start) begin
          // start has priority over a coincident rd_req.
          state_d        = ST_POWERUP;
          cnt_d          = '0;
          cmd0_tries_d   = '0;
          acmd41_tries_d = '0;
          err_code_d     = ERR_NONE;
          cs_n_d         = 1'b1;
        end else if (state_q == ST_READY && rd_req) begin
          rd_addr_d = rd_addr;
          step_d    = STEP_CMD17;
          state_d   = ST_ISSUE;
        end
      end

      ST_POWERUP: begin
        if (cnt_q == 16'(INIT_CLKS - 1)) begin
          state_d = ST_ISSUE;
          step_d  = STEP_CMD0;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_ISSUE: begin
        cmd_send_d  = 1'b1;
        cmd_index_d = step_index(step_q);
        case (step_q)
          STEP_CMD16: cmd_arg_d = BLOCK_LEN;
          STEP_CMD17: cmd_arg_d = rd_addr_q;
          default:    cmd_arg_d = 32'd0;
        endcase
        state_d = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        // cmd_done during the load cycle belongs to the previous frame.
        if (!cmd_send_q && cmd_done) begin
          rx_arm  = 1'b1;
          state_d = ST_RESP_WAIT;
        end
      end

      ST_RESP_WAIT: begin
        if (rx_found) begin
          state_d = ST_RESP_SHIFT;
        end else if (rx_timeout) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_NO_RESP;
          cs_n_d     = 1'b1;
        end
      end

      ST_RESP_SHIFT: begin
        if (rx_valid) begin
          last_r1_d = rx_r1;
          state_d   = ST_GAP;
          cnt_d     = '0;
        end
      end

      ST_GAP: begin
        if (cnt_q == 16'(GAP_CLKS - 1)) begin
          state_d = ST_DECIDE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DECIDE: begin
        case (step_q)
          STEP_CMD0: begin
            if (last_r1_q == R1_IDLE) begin
              step_d  = STEP_CMD55;
              state_d = ST_ISSUE;
            end else if (cmd0_tries_q == 16'(CMD0_TRIES - 1)) begin
              state_d    = ST_ERROR;
              err_code_d = ERR_CMD0;
              cs_n_d     = 1'b1;
            end else begin
              cmd0_tries_d = cmd0_tries_q + 16'd1;
              state_d      = ST_ISSUE;
            end
          end
          STEP_CMD55: begin
            // Only the idle bit may be set in a CMD55 response.
            if ((last_r1_q & ~R1_IDLE) == 8'h00) begin
              step_d  = STEP_ACMD41;
              state_d = ST_ISSUE;
            end else begin
              state_d    = ST_ERROR;
              err_code_d = ERR_CMD55;
              cs_n_d     = 1'b1;
            end
          end
          STEP_ACMD41: begin
            if (last_r1_q == 8'h00) begin
              step_d  = STEP_CMD16;
              state_d = ST_ISSUE;
            end else if (last_r1_q == R1_IDLE) begin
              if (acmd41_tries_q == 16'(ACMD41_TRIES - 1)) begin
                state_d    = ST_ERROR;
                err_code_d = ERR_ACMD41_TMO;
                cs_n_d     = 1'b1;
              end else begin
                acmd41_tries_d = acmd41_tries_q + 16'd1;
                step_d         = STEP_CMD55;
                state_d        = ST_ISSUE;
              end
            end else begin
              state_d    = ST_ERROR;
              err_code_d = ERR_ACMD41_REJ;
              cs_n_d     = 1'b1;
            end
          end
          STEP_CMD16: begin
            if (last_r1_q == 8'h00) begin
              state_d = ST_READY;
            end else begin
              state_d    = ST_ERROR;
              err_code_d = ERR_CMD16;
              cs_n_d     = 1'b1;
            end
          end
          STEP_CMD17: begin
            // Any R1 completes the read command; the caller checks last_r1.
            rd_done_d = 1'b1;
            state_d   = ST_READY;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d  = !(state_d == ST_IDLE || state_d == ST_READY || state_d == ST_ERROR);
    ready_d = (state_d == ST_READY);
    error_d = (state_d == ST_ERROR);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      step_q         <= STEP_CMD0;
      cnt_q          <= '0;
      cmd0_tries_q   <= '0;
      acmd41_tries_q <= '0;
      cmd_send_q     <= 1'b0;
      cmd_index_q    <= '0;
      cmd_arg_q      <= '0;
      cs_n_q         <= 1'b1;
      rd_done_q      <= 1'b0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
      last_r1_q      <= 8'hFF;
      rd_addr_q      <= '0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      cnt_q          <= cnt_d;
      cmd0_tries_q   <= cmd0_tries_d;
      acmd41_tries_q <= acmd41_tries_d;
      cmd_send_q     <= cmd_send_d;
      cmd_index_q    <= cmd_index_d;
      cmd_arg_q      <= cmd_arg_d;
      cs_n_q         <= cs_n_d;
      rd_done_q      <= rd_done_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      last_r1_q      <= last_r1_d;
      rd_addr_q      <= rd_addr_d;
    end
  end

  assign cmd_send  = cmd_send_q;
  assign cmd_index = cmd_index_q;
  assign cmd_arg   = cmd_arg_q;
  assign cs_n      = cs_n_q;
  assign rd_done   = rd_done_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign last_r1   = last_r1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Directed bench for sd_init_ctrl with a behavioural serializer and SD card.
module tb_sd_init_ctrl;
  import sd_pkg::*;

  localparam int INIT_CLKS    = 80;
  localparam int NCR_MAX      = 128;
  localparam int GAP_CLKS     = 8;
  localparam int CMD0_TRIES   = 8;
  localparam int ACMD41_TRIES = 4;
  localparam int TX_CLKS      = 12;

  localparam int M_GOOD      = 0;
  localparam int M_MUTE      = 1;
  localparam int M_ACMD_BUSY = 2;
  localparam int M_CMD16_BAD = 3;
  localparam int M_CMD0_BAD  = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start   = 1'b0;
  logic        SDin    = 1'b1;
  logic        cmd_done = 1'b0;
  logic        rd_req  = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic        cmd_send;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cs_n;
  logic        rd_done;
  logic        busy;
  logic        ready;
  logic        error;
  logic [2:0]  err_code;
  logic [7:0]  last_r1;
  sd_state_e   dbg_state;
  rx_state_e   dbg_rx_state;

  sd_init_ctrl #(
    .INIT_CLKS    (INIT_CLKS),
    .NCR_MAX      (NCR_MAX),
    .GAP_CLKS     (GAP_CLKS),
    .CMD0_TRIES   (CMD0_TRIES),
    .ACMD41_TRIES (ACMD41_TRIES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .SDin         (SDin),
    .cmd_done     (cmd_done),
    .cmd_send     (cmd_send),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cs_n         (cs_n),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_done      (rd_done),
    .busy         (busy),
    .ready        (ready),
    .error        (error),
    .err_code     (err_code),
    .last_r1      (last_r1),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // ---------------- serializer + card model ----------------
  // Updates 2 time units after each rising edge so inputs are stable at the
  // next edge. cmd_done stays high until the edge after a load, then drops
  // for TX_CLKS clocks; the card answers two idle clocks after the frame.
  int          card_mode = M_GOOD;
  int          acmd_seen = 0;
  int          tx_cnt    = 0;
  int          resp_wait = 0;
  int          resp_bit  = -1;
  logic        load_seen = 1'b0;
  logic        resp_en   = 1'b0;
  logic [7:0]  resp_byte = 8'hFF;
  logic [5:0]  obs_idx_q[$];
  logic [31:0] obs_arg_q[$];

  always @(posedge clock) begin
    #2;
    SDin = 1'b1;
    if (resp_bit >= 0) begin
      SDin = resp_byte[resp_bit];
      resp_bit--;
    end else if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) resp_bit = 7;
    end
    if (load_seen) begin
      load_seen = 1'b0;
      cmd_done  = 1'b0;
      tx_cnt    = TX_CLKS;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        cmd_done = 1'b1;
        if (resp_en) resp_wait = 2;
      end
    end
    if (cmd_send) begin
      load_seen = 1'b1;
      obs_idx_q.push_back(cmd_index);
      obs_arg_q.push_back(cmd_arg);
      resp_en = 1'b1;
      case (cmd_index)
        6'd0: begin
          acmd_seen = 0;
          resp_byte = (card_mode == M_CMD0_BAD) ? 8'h00 : 8'h01;
          resp_en   = (card_mode != M_MUTE);
        end
        6'd55: resp_byte = 8'h01;
        6'd41: begin
          acmd_seen++;
          resp_byte = (card_mode == M_ACMD_BUSY || acmd_seen <= 2) ? 8'h01 : 8'h00;
        end
        6'd16: resp_byte = (card_mode == M_CMD16_BAD) ? 8'h04 : 8'h00;
        default: resp_byte = 8'h00;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmds(input string tag);
    chk({tag, "_ncmds"}, obs_idx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_idx_q.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), obs_idx_q[i], exp_q[i]);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_send"},  cmd_send,  0);
    chk({tag, "_cmd_index"}, cmd_index, 0);
    chk({tag, "_cmd_arg"},   cmd_arg,   0);
    chk({tag, "_cs_n"},      cs_n,      1);
    chk({tag, "_rd_done"},   rd_done,   0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_ready"},     ready,     0);
    chk({tag, "_error"},     error,     0);
    chk({tag, "_err_code"},  err_code,  0);
    chk({tag, "_last_r1"},   last_r1,   8'hFF);
    chk({tag, "_state"},     dbg_state, ST_IDLE);
    chk({tag, "_rx_state"},  dbg_rx_state, RX_IDLE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_for_state(input string tag, input sd_state_e st, input int budget);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_reached"}, (dbg_state === st) ? 1 : 0, 1);
  endtask

  task automatic load_good_seq();
    exp_q = '{6'd0, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd16};
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int cs_hi;
    int n;
    int rd_pulses;
    int acmd_cnt;
    logic hit;

    // Reset state.
    repeat (3) @(negedge clock);
    chk_reset_values("rst");
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_rst", dbg_state, ST_IDLE);

    // 1. Good card: 80 power-up clocks, then full init sequence.
    card_mode = M_GOOD;
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    chk("init_busy", busy, 1);
    cs_hi = 0;
    while (cs_n === 1'b1 && cs_hi < 200) begin
      cs_hi++;
      @(negedge clock);
    end
    chk("powerup_clks", cs_hi, INIT_CLKS);
    wait_for_state("init", ST_READY, 2000);
    load_good_seq();
    chk_cmds("init");
    if (obs_arg_q.size() == 8) chk("cmd16_arg", obs_arg_q[7], 32'd512);
    else chk("cmd16_arg_present", obs_arg_q.size(), 8);
    chk("init_ready", ready, 1);
    chk("init_busy_low", busy, 0);
    chk("init_last_r1", last_r1, 8'h00);
    chk("init_err_code", err_code, 0);
    chk("init_cs_n", cs_n, 0);

    // 2. CMD17 read; a start pulse while busy must be ignored.
    obs_idx_q.delete();
    obs_arg_q.delete();
    @(negedge clock);
    rd_addr = 32'h0000_0200;
    rd_req  = 1'b1;
    @(negedge clock);
    rd_req  = 1'b0;
    rd_addr = 32'hDEAD_BEEF;
    chk("rd_busy", busy, 1);
    repeat (4) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (rd_done === 1'b1) rd_pulses++;
    end
    chk("rd_done_pulses", rd_pulses, 1);
    chk("rd_ready", ready, 1);
    chk("rd_ncmds", obs_idx_q.size(), 1);
    if (obs_idx_q.size() >= 1) begin
      chk("rd_index", obs_idx_q[0], 6'd17);
      chk("rd_arg", obs_arg_q[0], 32'h0000_0200);
    end
    chk("rd_last_r1", last_r1, 8'h00);

    // 3. CMD0 never answered with 0x01: all tries used, err 2.
    card_mode = M_CMD0_BAD;
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    wait_for_state("cmd0", ST_ERROR, 3000);
    chk("cmd0_err_code", err_code, ERR_CMD0);
    exp_q.delete();
    for (int i = 0; i < CMD0_TRIES; i++) exp_q.push_back(6'd0);
    chk_cmds("cmd0");

    // 4. No response after CMD0: timeout NCR_MAX clocks after the edge
    //    that first sees cmd_done high.
    card_mode = M_MUTE;
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    n = 0;
    while (!(dbg_state === ST_TX_WAIT && cmd_send === 1'b0 && cmd_done === 1'b1) && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("ncr_done_seen", (n < 400) ? 1 : 0, 1);
    n = 0;
    while (error !== 1'b1 && n < NCR_MAX + 20) begin
      @(negedge clock);
      n++;
    end
    chk("ncr_clocks", n - 1, NCR_MAX);
    chk("ncr_err_code", err_code, ERR_NO_RESP);
    chk("ncr_cs_n", cs_n, 1);
    chk("ncr_busy", busy, 0);
    chk("ncr_ncmds", obs_idx_q.size(), 1);

    // 5. ACMD41 stays busy: ACMD41_TRIES issues then err 5.
    card_mode = M_ACMD_BUSY;
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    chk("acmd_err_cleared", err_code, 0);
    wait_for_state("acmd", ST_ERROR, 3000);
    chk("acmd_err_code", err_code, ERR_ACMD41_TMO);
    acmd_cnt = 0;
    foreach (obs_idx_q[i]) if (obs_idx_q[i] == 6'd41) acmd_cnt++;
    chk("acmd_issues", acmd_cnt, ACMD41_TRIES);
    chk("acmd_cs_n", cs_n, 1);
    chk("acmd_error", error, 1);

    // 6. CMD16 rejected (illegal command), then recovery with a good card.
    card_mode = M_CMD16_BAD;
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    wait_for_state("cmd16", ST_ERROR, 2000);
    chk("cmd16_err_code", err_code, ERR_CMD16);
    chk("cmd16_last_r1", last_r1, R1_ILLEGAL);
    card_mode = M_GOOD;
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    chk("recover_err_clear", err_code, 0);
    chk("recover_error_low", error, 0);
    wait_for_state("recover", ST_READY, 2000);
    chk("recover_ready", ready, 1);

    // 7. Async reset while shifting an ACMD41 response, then re-init.
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    n = 0;
    hit = 1'b0;
    while (!hit && n < 2000) begin
      @(negedge clock);
      n++;
      hit = (dbg_state === ST_RESP_SHIFT && cmd_index === 6'd41);
    end
    chk("mid_shift_reached", hit, 1);
    reset = 1'b1;
    #1;
    chk_reset_values("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_idle", dbg_state, ST_IDLE);
    obs_idx_q.delete();
    obs_arg_q.delete();
    pulse_start();
    wait_for_state("reinit", ST_READY, 2000);
    load_good_seq();
    chk_cmds("reinit");
    chk("reinit_last_r1", last_r1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
